reservation_station: RTL and testbench
======================================

RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 SHALL have parameter RS_DEPTH, default 8, meaning number of entries (power of 2, 2..16).
REQ-002 SHALL have parameter GENERATED_IMMEDIATE_WIDTH, default `REG_VAL_WIDTH, meaning immediate field width.
REQ-003 SHALL have the following ports, one per line (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_inst_in  in  1  the issue stage presents an instruction.
- src_val1, src_val2  in  `REG_VAL_WIDTH  operand values from the register read stage.
- src_rdy1_in, src_rdy2_in  in  1  operand value is final (not pending on the CDB).
- src_phy_reg1_in, src_phy_reg2_in, dst_phy_reg_in  in  `PHYSICAL_REG_NUM_WIDTH  physical tags.
- control_in  in  control_t  decoded control.
- pc_in  in  `INST_ADDR_WIDTH  instruction PC.
- generated_immediate_in  in  GENERATED_IMMEDIATE_WIDTH  immediate.
- inst_tag_in  in  `ROB_SIZE_WIDTH  ROB tag.
- CDB_if  CDB_IF.slave  -  broadcast: valid, register_addr, register_val.
- flush  in  1  discard all contents.
- exec_ready  in  1  execution unit accepts the issued instruction.
- rs_full  out  1  no free entry; used as stall upstream.
- issue_valid  out  1  issue output holds an instruction.
- issue_val1, issue_val2, issue_dst_phy_reg, issue_control, issue_pc, issue_immediate, issue_tag  out  widths as inputs  issued instruction fields.

Function
REQ-004 Each entry SHALL hold: valid, rdy1, rdy2, val1, val2, src tags, dst tag, control, pc, immediate, ROB tag, and age.
REQ-005 rs_full SHALL be combinational, asserted when all RS_DEPTH entries are valid. It SHALL NOT account for a same-cycle issue.
REQ-006 Insertion SHALL occur at the clock edge when valid_inst_in=1, rs_full=0 and flush=0, into the lowest-index free entry.
REQ-007 valid_inst_in while rs_full=1 SHALL be ignored; upstream holds the instruction.
REQ-008 Wakeup: when CDB_if.valid=1, every valid entry with rdyN=0 and srcN tag == CDB_if.register_addr SHALL capture register_val into valN and set rdyN=1 at the edge.
REQ-009 An instruction inserted in the same cycle as a matching CDB broadcast SHALL be stored with the CDB value and rdy=1, overriding src_valN/src_rdyN_in.
REQ-010 An entry SHALL be eligible for selection when valid, rdy1=1 and rdy2=1 at the start of the cycle. Wakeup-to-select latency SHALL be 1 cycle.
REQ-011 The output register SHALL load the selected entry when issue_valid=0 or exec_ready=1. The entry SHALL be freed at the same edge.
REQ-012 When issue_valid=1 and exec_ready=0, all issue_* outputs SHALL hold stable, and no entry SHALL be freed.
REQ-013 issue_valid SHALL fall at the edge where exec_ready=1 and no entry is eligible.
REQ-014 Minimum latency from insertion with both operands ready to issue_valid=1 SHALL be 2 edges.
REQ-015 An entry freed by issue SHALL be reusable by insertion no earlier than the next cycle.
REQ-016 flush=1 SHALL clear all entry valid bits and issue_valid at the edge, with priority over insert, wakeup and issue.

Reset
REQ-017 While reset=0, all entry valid bits, issue_valid and ages SHALL be 0.
REQ-018 While reset=0, issue data outputs SHALL be 0 and issue_control SHALL be `NOP_CONTROL.
REQ-019 rs_full SHALL be 0 during reset.
REQ-020 Reset asserted mid-operation SHALL discard all contents immediately, without waiting for a clock edge.

Configuration
REQ-021 With RS_OLDEST_FIRST_EN defined, selection SHALL pick the eligible entry with the largest age.
REQ-022 With RS_OLDEST_FIRST_EN defined, age SHALL be set to 0 on insert, and each valid entry's age SHALL be incremented each cycle, saturating at RS_DEPTH-1. Ties SHALL go to the lowest index.
REQ-023 Without RS_OLDEST_FIRST_EN, selection SHALL pick the lowest-index eligible entry, and age logic SHALL be absent.

Verification
REQ-024 Insert tag 3 with rdy1=rdy2=1, val1=5, val2=7, exec_ready=1 -> issue_valid=1 two edges later with issue_val1=5, issue_val2=7, issue_tag=3.
REQ-025 Insert with rdy2=0, src2=12; then broadcast CDB valid, addr=12, val=0x55 -> the next cycle the entry is selected and issue_val2=0x55.
REQ-026 Insert RS_DEPTH=8 non-ready instructions -> rs_full=1, and a ninth valid_inst_in is not stored. Wake one entry -> it issues and rs_full=0 one edge later.
REQ-027 Hold exec_ready=0 with issue_valid=1 for 4 cycles while a CDB broadcast occurs -> issue_* outputs are unchanged and entry count is unchanged.
REQ-028 Assert flush with 5 entries valid and the same-cycle insert -> the next cycle issue_valid=0 and rs_full=0, and no issue occurs for 3 cycles.
REQ-029 With RS_OLDEST_FIRST_EN, insert A into index 2, free index 0, then insert ready B into index 0 while A becomes ready -> A issues before B. Without the macro, B issues first.

Source files
------------

// File: rtl/reservation_station_if.sv
// Shared width defaults, decoded-control type and the CDB broadcast interface
// consumed by reservation_station.
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 6
`endif
`ifndef NOP_CONTROL
`define NOP_CONTROL '0
`endif

package rs_pkg;
  typedef struct packed {
    logic [3:0] alu_op;
    logic       use_imm;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
  } control_t;
endpackage

interface CDB_IF;
  logic                               valid;
  logic [`PHYSICAL_REG_NUM_WIDTH-1:0] register_addr;
  logic [`REG_VAL_WIDTH-1:0]          register_val;

  modport master (output valid, register_addr, register_val);
  modport slave  (input  valid, register_addr, register_val);
endinterface

// File: rtl/reservation_station.sv
// Out-of-order reservation station: tag-matched CDB wakeup, one issue per cycle
// into a stallable output register. Define RS_OLDEST_FIRST_EN for age-based select.
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 6
`endif
`ifndef NOP_CONTROL
`define NOP_CONTROL '0
`endif

module reservation_station
  import rs_pkg::*;
#(
  parameter int RS_DEPTH                  = 8,
  parameter int GENERATED_IMMEDIATE_WIDTH = `REG_VAL_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 valid_inst_in,
  input  logic [`REG_VAL_WIDTH-1:0]            src_val1,
  input  logic [`REG_VAL_WIDTH-1:0]            src_val2,
  input  logic                                 src_rdy1_in,
  input  logic                                 src_rdy2_in,
  input  logic [`PHYSICAL_REG_NUM_WIDTH-1:0]   src_phy_reg1_in,
  input  logic [`PHYSICAL_REG_NUM_WIDTH-1:0]   src_phy_reg2_in,
  input  logic [`PHYSICAL_REG_NUM_WIDTH-1:0]   dst_phy_reg_in,
  input  control_t                             control_in,
  input  logic [`INST_ADDR_WIDTH-1:0]          pc_in,
  input  logic [GENERATED_IMMEDIATE_WIDTH-1:0] generated_immediate_in,
  input  logic [`ROB_SIZE_WIDTH-1:0]           inst_tag_in,
  CDB_IF.slave                                 CDB_if,
  input  logic                                 flush,
  input  logic                                 exec_ready,
  output logic                                 rs_full,
  output logic                                 issue_valid,
  output logic [`REG_VAL_WIDTH-1:0]            issue_val1,
  output logic [`REG_VAL_WIDTH-1:0]            issue_val2,
  output logic [`PHYSICAL_REG_NUM_WIDTH-1:0]   issue_dst_phy_reg,
  output control_t                             issue_control,
  output logic [`INST_ADDR_WIDTH-1:0]          issue_pc,
  output logic [GENERATED_IMMEDIATE_WIDTH-1:0] issue_immediate,
  output logic [`ROB_SIZE_WIDTH-1:0]           issue_tag
);
  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int VW    = `REG_VAL_WIDTH;
  localparam int PW    = `PHYSICAL_REG_NUM_WIDTH;
  localparam int AW    = `INST_ADDR_WIDTH;
  localparam int IW    = GENERATED_IMMEDIATE_WIDTH;
  localparam int TW    = `ROB_SIZE_WIDTH;

  logic [RS_DEPTH-1:0] valid_vec;
  logic [RS_DEPTH-1:0] elig_vec;
  logic [VW-1:0]       val1_arr [RS_DEPTH];
  logic [VW-1:0]       val2_arr [RS_DEPTH];
  logic [PW-1:0]       dst_arr  [RS_DEPTH];
  control_t            ctrl_arr [RS_DEPTH];
  logic [AW-1:0]       pc_arr   [RS_DEPTH];
  logic [IW-1:0]       imm_arr  [RS_DEPTH];
  logic [TW-1:0]       tag_arr  [RS_DEPTH];
`ifdef RS_OLDEST_FIRST_EN
  logic [IDX_W-1:0]    age_arr  [RS_DEPTH];
`endif

  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             any_elig;
  logic             insert_en;
  logic             load_out;
  logic             issue_fire;
  logic             cdb_hit1;
  logic             cdb_hit2;
  logic             issue_valid_reg;

  assign rs_full    = &valid_vec;
  assign insert_en  = valid_inst_in && !rs_full && !flush;
  assign load_out   = !issue_valid_reg || exec_ready;
  assign issue_fire = load_out && any_elig && !flush;
  // A broadcast arriving with the instruction itself must not be missed.
  assign cdb_hit1   = CDB_if.valid && (src_phy_reg1_in == CDB_if.register_addr);
  assign cdb_hit2   = CDB_if.valid && (src_phy_reg2_in == CDB_if.register_addr);
  assign issue_valid = issue_valid_reg;

  always_comb begin
    free_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!valid_vec[i]) free_idx = IDX_W'(i);
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  logic [IDX_W-1:0] best_age;
  always_comb begin
    sel_idx  = '0;
    any_elig = 1'b0;
    best_age = '0;
    // Strict compare keeps the lowest index on equal ages.
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (elig_vec[i] && (!any_elig || age_arr[i] > best_age)) begin
        sel_idx  = IDX_W'(i);
        best_age = age_arr[i];
        any_elig = 1'b1;
      end
    end
  end
`else
  always_comb begin
    sel_idx  = '0;
    any_elig = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (elig_vec[i] && !any_elig) begin
        sel_idx  = IDX_W'(i);
        any_elig = 1'b1;
      end
    end
  end
`endif

  for (genvar gi = 0; gi < RS_DEPTH; gi++) begin : g_entry
    logic          valid_reg, rdy1_reg, rdy2_reg;
    logic [VW-1:0] val1_reg, val2_reg;
    logic [PW-1:0] src1_reg, src2_reg, dst_reg;
    control_t      ctrl_reg;
    logic [AW-1:0] pc_reg;
    logic [IW-1:0] imm_reg;
    logic [TW-1:0] tag_reg;
    logic          ins_here, free_here, wake1, wake2;

    assign ins_here  = insert_en && (free_idx == IDX_W'(gi));
    assign free_here = issue_fire && (sel_idx == IDX_W'(gi));
    assign wake1 = CDB_if.valid && valid_reg && !rdy1_reg && (src1_reg == CDB_if.register_addr);
    assign wake2 = CDB_if.valid && valid_reg && !rdy2_reg && (src2_reg == CDB_if.register_addr);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        valid_reg <= 1'b0;
        rdy1_reg  <= 1'b0;
        rdy2_reg  <= 1'b0;
        val1_reg  <= '0;
        val2_reg  <= '0;
        src1_reg  <= '0;
        src2_reg  <= '0;
        dst_reg   <= '0;
        ctrl_reg  <= `NOP_CONTROL;
        pc_reg    <= '0;
        imm_reg   <= '0;
        tag_reg   <= '0;
      end else if (flush) begin
        valid_reg <= 1'b0;
      end else if (ins_here) begin
        valid_reg <= 1'b1;
        rdy1_reg  <= src_rdy1_in || cdb_hit1;
        rdy2_reg  <= src_rdy2_in || cdb_hit2;
        val1_reg  <= cdb_hit1 ? CDB_if.register_val : src_val1;
        val2_reg  <= cdb_hit2 ? CDB_if.register_val : src_val2;
        src1_reg  <= src_phy_reg1_in;
        src2_reg  <= src_phy_reg2_in;
        dst_reg   <= dst_phy_reg_in;
        ctrl_reg  <= control_in;
        pc_reg    <= pc_in;
        imm_reg   <= generated_immediate_in;
        tag_reg   <= inst_tag_in;
      end else begin
        if (free_here) valid_reg <= 1'b0;
        if (wake1) begin
          rdy1_reg <= 1'b1;
          val1_reg <= CDB_if.register_val;
        end
        if (wake2) begin
          rdy2_reg <= 1'b1;
          val2_reg <= CDB_if.register_val;
        end
      end
    end

`ifdef RS_OLDEST_FIRST_EN
    logic [IDX_W-1:0] age_reg;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                         age_reg <= '0;
      else if (flush || ins_here)                         age_reg <= '0;
      else if (valid_reg && age_reg != IDX_W'(RS_DEPTH - 1)) age_reg <= age_reg + 1'b1;
    end
    assign age_arr[gi] = age_reg;
`endif

    assign valid_vec[gi] = valid_reg;
    assign elig_vec[gi]  = valid_reg && rdy1_reg && rdy2_reg;
    assign val1_arr[gi]  = val1_reg;
    assign val2_arr[gi]  = val2_reg;
    assign dst_arr[gi]   = dst_reg;
    assign ctrl_arr[gi]  = ctrl_reg;
    assign pc_arr[gi]    = pc_reg;
    assign imm_arr[gi]   = imm_reg;
    assign tag_arr[gi]   = tag_reg;
  end

  // Output register only advances when empty or consumed; otherwise it holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_valid_reg   <= 1'b0;
      issue_val1        <= '0;
      issue_val2        <= '0;
      issue_dst_phy_reg <= '0;
      issue_control     <= `NOP_CONTROL;
      issue_pc          <= '0;
      issue_immediate   <= '0;
      issue_tag         <= '0;
    end else if (flush) begin
      issue_valid_reg <= 1'b0;
    end else if (load_out) begin
      issue_valid_reg <= any_elig;
      if (any_elig) begin
        issue_val1        <= val1_arr[sel_idx];
        issue_val2        <= val2_arr[sel_idx];
        issue_dst_phy_reg <= dst_arr[sel_idx];
        issue_control     <= ctrl_arr[sel_idx];
        issue_pc          <= pc_arr[sel_idx];
        issue_immediate   <= imm_arr[sel_idx];
        issue_tag         <= tag_arr[sel_idx];
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed-vector bench for reservation_station: issue latency, wakeup, full,
// stall, flush, selection order and asynchronous reset.
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 6
`endif
`ifndef NOP_CONTROL
`define NOP_CONTROL '0
`endif

module tb_reservation_station;
  import rs_pkg::*;

  localparam int VW = `REG_VAL_WIDTH;
  localparam int PW = `PHYSICAL_REG_NUM_WIDTH;
  localparam int AW = `INST_ADDR_WIDTH;
  localparam int TW = `ROB_SIZE_WIDTH;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_inst_in;
  logic [VW-1:0] src_val1, src_val2;
  logic          src_rdy1_in, src_rdy2_in;
  logic [PW-1:0] src_phy_reg1_in, src_phy_reg2_in, dst_phy_reg_in;
  control_t      control_in;
  logic [AW-1:0] pc_in;
  logic [VW-1:0] generated_immediate_in;
  logic [TW-1:0] inst_tag_in;
  logic          flush, exec_ready;
  logic          rs_full, issue_valid;
  logic [VW-1:0] issue_val1, issue_val2;
  logic [PW-1:0] issue_dst_phy_reg;
  control_t      issue_control;
  logic [AW-1:0] issue_pc;
  logic [VW-1:0] issue_immediate;
  logic [TW-1:0] issue_tag;

  int vectors     = 0;
  int miscompares = 0;

  CDB_IF cdb ();

  reservation_station #(.RS_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .valid_inst_in(valid_inst_in),
    .src_val1(src_val1), .src_val2(src_val2),
    .src_rdy1_in(src_rdy1_in), .src_rdy2_in(src_rdy2_in),
    .src_phy_reg1_in(src_phy_reg1_in), .src_phy_reg2_in(src_phy_reg2_in),
    .dst_phy_reg_in(dst_phy_reg_in), .control_in(control_in), .pc_in(pc_in),
    .generated_immediate_in(generated_immediate_in), .inst_tag_in(inst_tag_in),
    .CDB_if(cdb), .flush(flush), .exec_ready(exec_ready),
    .rs_full(rs_full), .issue_valid(issue_valid),
    .issue_val1(issue_val1), .issue_val2(issue_val2),
    .issue_dst_phy_reg(issue_dst_phy_reg), .issue_control(issue_control),
    .issue_pc(issue_pc), .issue_immediate(issue_immediate), .issue_tag(issue_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, want summary before it");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_inst(input int tag, input int r1, input int s1, input int v1,
                            input int r2, input int s2, input int v2);
    valid_inst_in          = 1'b1;
    inst_tag_in            = TW'(tag);
    src_rdy1_in            = (r1 != 0);
    src_phy_reg1_in        = PW'(s1);
    src_val1               = VW'(v1);
    src_rdy2_in            = (r2 != 0);
    src_phy_reg2_in        = PW'(s2);
    src_val2               = VW'(v2);
    dst_phy_reg_in         = PW'(tag + 32);
    pc_in                  = AW'(32'h1000 + tag * 4);
    generated_immediate_in = VW'(tag * 3);
    control_in             = control_t'(8'hA5);
  endtask

  task automatic bcast(input int addr, input int val);
    cdb.valid         = 1'b1;
    cdb.register_addr = PW'(addr);
    cdb.register_val  = VW'(val);
  endtask

  task automatic idle();
    valid_inst_in = 1'b0;
    cdb.valid     = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if ({issue_valid, rs_full} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_flags: valid=%0b full=%0b want 0/0", issue_valid, rs_full);
    end
    vectors++;
    if ({issue_val1, issue_val2, issue_pc, issue_immediate, issue_tag, issue_dst_phy_reg} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: v1=%0h v2=%0h pc=%0h imm=%0h tag=%0h dst=%0h want all 0",
               issue_val1, issue_val2, issue_pc, issue_immediate, issue_tag, issue_dst_phy_reg);
    end
    vectors++;
    if (issue_control !== control_t'(`NOP_CONTROL)) begin
      miscompares++;
      $display("FAIL reset_control: got %0h want %0h", issue_control, control_t'(`NOP_CONTROL));
    end
    $display("test_reset: flags and outputs sampled during reset");
  endtask

  task automatic test_basic_issue();
    exec_ready = 1'b1;
    drive_inst(3, 1, 0, 5, 1, 0, 7);
    tick();
    idle();
    vectors++;
    if (issue_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_early: valid=%0b one edge after insert, want 0", issue_valid);
    end
    tick();
    vectors++;
    if ({issue_valid, issue_tag, issue_val1, issue_val2} !== {1'b1, TW'(3), VW'(5), VW'(7)}) begin
      miscompares++;
      $display("FAIL basic_issue: valid=%0b tag=%0d v1=%0d v2=%0d want 1/3/5/7",
               issue_valid, issue_tag, issue_val1, issue_val2);
    end
    vectors++;
    if ({issue_dst_phy_reg, issue_pc, issue_immediate, issue_control} !==
        {PW'(35), AW'(32'h100C), VW'(9), control_t'(8'hA5)}) begin
      miscompares++;
      $display("FAIL basic_fields: dst=%0d pc=%0h imm=%0d ctl=%0h want 35/100c/9/a5",
               issue_dst_phy_reg, issue_pc, issue_immediate, issue_control);
    end
    tick();
    vectors++;
    if (issue_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_drain: valid=%0b with nothing eligible, want 0", issue_valid);
    end
    $display("test_basic_issue: tag 3 issued two edges after insert");
  endtask

  task automatic test_wakeup();
    exec_ready = 1'b1;
    drive_inst(4, 1, 0, 1, 0, 12, 32'hDEAD);
    tick();
    idle();
    bcast(12, 32'h55);
    tick();
    idle();
    vectors++;
    if (issue_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wake_early: valid=%0b at wakeup edge, want 0", issue_valid);
    end
    tick();
    vectors++;
    if ({issue_valid, issue_tag, issue_val1, issue_val2} !== {1'b1, TW'(4), VW'(1), VW'(32'h55)}) begin
      miscompares++;
      $display("FAIL wake_issue: valid=%0b tag=%0d v1=%0h v2=%0h want 1/4/1/55",
               issue_valid, issue_tag, issue_val1, issue_val2);
    end
    tick();
    // Broadcast in the insertion cycle overrides both incoming operands.
    drive_inst(5, 0, 13, 32'h11, 0, 13, 32'h22);
    bcast(13, 32'h77);
    tick();
    idle();
    tick();
    vectors++;
    if ({issue_valid, issue_tag, issue_val1, issue_val2} !== {1'b1, TW'(5), VW'(32'h77), VW'(32'h77)}) begin
      miscompares++;
      $display("FAIL wake_on_insert: valid=%0b tag=%0d v1=%0h v2=%0h want 1/5/77/77",
               issue_valid, issue_tag, issue_val1, issue_val2);
    end
    tick();
    $display("test_wakeup: CDB capture later and in insertion cycle");
  endtask

  task automatic test_back_to_back();
    int exp_tag;
    exec_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive_inst(6 + i, 1, 0, i, 1, 0, 0);
      else idle();
      tick();
      if (i >= 1) begin
        exp_tag = 5 + i;
        vectors++;
        if (i < 4 && {issue_valid, issue_tag} !== {1'b1, TW'(exp_tag)}) begin
          miscompares++;
          $display("FAIL b2b_issue%0d: valid=%0b tag=%0d want 1/%0d", i, issue_valid, issue_tag, exp_tag);
        end else if (i == 4 && issue_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_drain: valid=%0b want 0", issue_valid);
        end
      end
    end
    $display("test_back_to_back: tags 6,7,8 issued on consecutive edges");
  endtask

  task automatic test_full();
    exec_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_inst(16 + i, 0, 20 + i, 0, 1, 0, i);
      tick();
      if (i == 6) begin
        vectors++;
        if (rs_full !== 1'b0) begin
          miscompares++;
          $display("FAIL full_at7: rs_full=%0b with 7 entries, want 0", rs_full);
        end
      end
    end
    idle();
    vectors++;
    if (rs_full !== 1'b1) begin
      miscompares++;
      $display("FAIL full_at8: rs_full=%0b with 8 entries, want 1", rs_full);
    end
    drive_inst(30, 1, 0, 0, 1, 0, 0);
    tick();
    idle();
    bcast(23, 32'h33);
    tick();
    idle();
    vectors++;
    if ({rs_full, issue_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL full_ninth: full=%0b valid=%0b after ninth and wake, want 1/0", rs_full, issue_valid);
    end
    tick();
    vectors++;
    if ({rs_full, issue_valid, issue_tag, issue_val1, issue_val2} !==
        {1'b0, 1'b1, TW'(19), VW'(32'h33), VW'(3)}) begin
      miscompares++;
      $display("FAIL full_issue: full=%0b valid=%0b tag=%0d v1=%0h v2=%0h want 0/1/19/33/3",
               rs_full, issue_valid, issue_tag, issue_val1, issue_val2);
    end
    tick();
    vectors++;
    if (issue_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL full_drain: valid=%0b tag=%0d, want 0", issue_valid, issue_tag);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    $display("test_full: full at 8 entries, ninth ignored, wake frees a slot");
  endtask

  task automatic test_stall();
    exec_ready = 1'b0;
    drive_inst(1, 1, 0, 32'h10, 1, 0, 32'h20);
    tick();
    drive_inst(2, 0, 30, 0, 1, 0, 32'h22);
    tick();
    idle();
    for (int k = 0; k < 4; k++) begin
      if (k == 1) bcast(30, 32'h99);
      tick();
      idle();
      vectors++;
      if ({issue_valid, issue_tag, issue_val1, issue_val2} !== {1'b1, TW'(1), VW'(32'h10), VW'(32'h20)}) begin
        miscompares++;
        $display("FAIL stall_hold%0d: valid=%0b tag=%0d v1=%0h v2=%0h want 1/1/10/20",
                 k, issue_valid, issue_tag, issue_val1, issue_val2);
      end
    end
    exec_ready = 1'b1;
    tick();
    vectors++;
    if ({issue_valid, issue_tag, issue_val1, issue_val2} !== {1'b1, TW'(2), VW'(32'h99), VW'(32'h22)}) begin
      miscompares++;
      $display("FAIL stall_release: valid=%0b tag=%0d v1=%0h v2=%0h want 1/2/99/22",
               issue_valid, issue_tag, issue_val1, issue_val2);
    end
    tick();
    vectors++;
    if (issue_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_drain: valid=%0b tag=%0d, want 0", issue_valid, issue_tag);
    end
    $display("test_stall: outputs held 4 cycles under exec_ready=0");
  endtask

  task automatic test_flush();
    exec_ready = 1'b0;
    drive_inst(39, 1, 0, 1, 1, 0, 2);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive_inst(40 + i, 0, 50 + i, 0, 1, 0, 0);
      tick();
    end
    idle();
    vectors++;
    if ({issue_valid, issue_tag} !== {1'b1, TW'(39)}) begin
      miscompares++;
      $display("FAIL flush_setup: valid=%0b tag=%0d want 1/39", issue_valid, issue_tag);
    end
    flush = 1'b1;
    drive_inst(45, 1, 0, 0, 1, 0, 0);
    tick();
    flush = 1'b0;
    idle();
    vectors++;
    if ({issue_valid, rs_full} !== 2'b00) begin
      miscompares++;
      $display("FAIL flush_clear: valid=%0b full=%0b want 0/0", issue_valid, rs_full);
    end
    exec_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) bcast(50 + k, k);
      tick();
      idle();
      vectors++;
      if (issue_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_quiet%0d: valid=%0b tag=%0d want 0", k, issue_valid, issue_tag);
      end
    end
    $display("test_flush: 5 entries plus same-cycle insert discarded");
  endtask

  task automatic test_age_order();
    int first_tag, second_tag;
`ifdef RS_OLDEST_FIRST_EN
    first_tag  = 52;
    second_tag = 53;
`else
    first_tag  = 53;
    second_tag = 52;
`endif
    exec_ready = 1'b1;
    drive_inst(50, 0, 40, 0, 1, 0, 0);
    tick();
    drive_inst(51, 0, 41, 0, 1, 0, 0);
    tick();
    drive_inst(52, 0, 42, 0, 1, 0, 0);
    tick();
    idle();
    bcast(40, 32'h40);
    tick();
    idle();
    tick();
    vectors++;
    if ({issue_valid, issue_tag, issue_val1} !== {1'b1, TW'(50), VW'(32'h40)}) begin
      miscompares++;
      $display("FAIL age_free0: valid=%0b tag=%0d v1=%0h want 1/50/40", issue_valid, issue_tag, issue_val1);
    end
    drive_inst(53, 1, 0, 0, 1, 0, 0);
    bcast(42, 32'h42);
    tick();
    idle();
    tick();
    vectors++;
    if ({issue_valid, issue_tag} !== {1'b1, TW'(first_tag)}) begin
      miscompares++;
      $display("FAIL age_first: valid=%0b tag=%0d want 1/%0d", issue_valid, issue_tag, first_tag);
    end
    tick();
    vectors++;
    if ({issue_valid, issue_tag} !== {1'b1, TW'(second_tag)}) begin
      miscompares++;
      $display("FAIL age_second: valid=%0b tag=%0d want 1/%0d", issue_valid, issue_tag, second_tag);
    end
    tick();
    $display("test_age_order: issue order %0d then %0d", first_tag, second_tag);
  endtask

  task automatic test_async_reset();
    exec_ready = 1'b0;
    drive_inst(9, 1, 0, 0, 1, 0, 0);
    tick();
    for (int i = 0; i < 7; i++) begin
      drive_inst(10 + i, 0, 60 + i, 0, 1, 0, 0);
      tick();
    end
    idle();
    vectors++;
    if ({rs_full, issue_valid, issue_tag} !== {1'b1, 1'b1, TW'(9)}) begin
      miscompares++;
      $display("FAIL areset_setup: full=%0b valid=%0b tag=%0d want 1/1/9", rs_full, issue_valid, issue_tag);
    end
    reset = 1'b0;
    #2;
    vectors++;
    if ({rs_full, issue_valid, issue_tag, issue_val1} !== '0 || issue_control !== control_t'(`NOP_CONTROL)) begin
      miscompares++;
      $display("FAIL areset_now: full=%0b valid=%0b tag=%0d v1=%0h ctl=%0h want 0/0/0/0/nop",
               rs_full, issue_valid, issue_tag, issue_val1, issue_control);
    end
    tick();
    reset      = 1'b1;
    exec_ready = 1'b1;
    bcast(41, 1);
    tick();
    bcast(60, 2);
    tick();
    idle();
    tick();
    vectors++;
    if ({rs_full, issue_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL areset_empty: full=%0b valid=%0b tag=%0d want 0/0", rs_full, issue_valid, issue_tag);
    end
    $display("test_async_reset: contents dropped between edges");
  endtask

  initial begin
    reset                  = 1'b0;
    valid_inst_in          = 1'b0;
    src_val1               = '0;
    src_val2               = '0;
    src_rdy1_in            = 1'b0;
    src_rdy2_in            = 1'b0;
    src_phy_reg1_in        = '0;
    src_phy_reg2_in        = '0;
    dst_phy_reg_in         = '0;
    control_in             = control_t'(8'h00);
    pc_in                  = '0;
    generated_immediate_in = '0;
    inst_tag_in            = '0;
    flush                  = 1'b0;
    exec_ready             = 1'b0;
    cdb.valid              = 1'b0;
    cdb.register_addr      = '0;
    cdb.register_val       = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b1;
    tick();
    test_basic_issue();
    test_wakeup();
    test_back_to_back();
    test_full();
    test_stall();
    test_flush();
    test_age_order();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
